// File: rtl/inst_queue_pkg.sv
// Shared fetch-side definitions for the instruction queue: default widths,
// active-low enable encodings and the packed queue entry layout.
package inst_queue_pkg;

  localparam int AddrWidth = 32;
  localparam int InstWidth = 32;

  // Active-low enable encoding used by the fetch/decoder handshakes
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  // One buffered fetch result, PC in the upper bits
  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic [InstWidth-1:0] inst;
  } InstQueueEntry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decoder. Circular buffer of {pc, inst}
// with a first-word-fall-through head, a full flag for fetch throttling and a
// single-cycle redirect flush. Occupancy (cnt) doubles as the queue state:
// 0 = empty, DEPTH = full, anything between = partial.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int ADDR  = AddrWidth,
  parameter int INST  = InstWidth,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic [INST-1:0] fetch_inst,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            fetch_e_,
  output logic            fetch_full,
  input  logic            flush_,
  output logic [INST-1:0] inst,
  output logic [ADDR-1:0] inst_pc,
  output logic            inst_e_,
  input  logic            stall
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

  logic [ADDR+INST-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW:0]          r_cnt;

  logic w_push;
  logic w_pop;
  logic w_flush;
  logic w_nonempty;

  assign w_flush    = (flush_ == Enable_);
  assign w_nonempty = (r_cnt != '0);

  assign fetch_full = (r_cnt == FullCnt);
  // flush_ masks the head valid combinationally so the decoder never consumes
  // an entry in the redirect cycle
  assign inst_e_    = (w_nonempty && !w_flush) ? Enable_ : Disable_;
  assign {inst_pc, inst} = w_nonempty ? r_mem[r_rd_ptr] : '0;

  // Full blocks the write even when a pop frees a slot in the same cycle
  assign w_push = (fetch_e_ == Enable_) && !fetch_full && !w_flush;
  assign w_pop  = (inst_e_ == Enable_) && !stall && !w_flush;

  // Storage write; contents need no reset since cnt gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {fetch_pc, fetch_inst};
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one edge
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4) with a scoreboard of expected
// entries in fetch order.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_e_;
  logic        fetch_full;
  logic        flush_;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_e_;
  logic        stall;

  int n_pass  = 0;
  int n_total = 0;

  InstQueueEntry_t sb[$];

  inst_queue #(.ADDR(32), .INST(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .fetch_inst (fetch_inst),
    .fetch_pc   (fetch_pc),
    .fetch_e_   (fetch_e_),
    .fetch_full (fetch_full),
    .flush_     (flush_),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_e_    (inst_e_),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " inst_e_"}, 64'(inst_e_), 64'(1));
    check({tag, " fetch_full"}, 64'(fetch_full), 64'(0));
    check({tag, " inst"}, 64'(inst), 64'(0));
    check({tag, " inst_pc"}, 64'(inst_pc), 64'(0));
  endtask

  // One clock cycle: drive, check head against the scoreboard, update model
  task automatic cycle(input logic fe, input logic [31:0] pc, input logic st, input logic fl);
    InstQueueEntry_t head;
    bit full_b;
    fetch_e_   = fe;
    fetch_pc   = pc;
    fetch_inst = inst_of(pc);
    stall      = st;
    flush_     = fl;
    #1;
    head = (sb.size() != 0) ? sb[0] : '0;
    check("inst_e_", 64'(inst_e_), (sb.size() != 0 && fl) ? 64'(0) : 64'(1));
    check("fetch_full", 64'(fetch_full), 64'(sb.size() == 4));
    check("inst_pc", 64'(inst_pc), 64'(head.pc));
    check("inst", 64'(inst), 64'(head.inst));
    if (!fl) begin
      sb.delete();
    end else begin
      full_b = (sb.size() == 4);
      if (!st && sb.size() != 0) void'(sb.pop_front());
      if (!fe && !full_b) sb.push_back({pc, inst_of(pc)});
      else if (!fe) $display("note: protocol error, write of pc %h while full was dropped", pc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with fetch attempting writes
    reset_     = 1'b0;
    fetch_e_   = 1'b0;
    fetch_pc   = 32'hdeadbeef;
    fetch_inst = inst_of(32'hdeadbeef);
    flush_     = 1'b1;
    stall      = 1'b0;
    #1;
    check_idle("reset t0");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("reset held");
    end
    reset_   = 1'b1;
    fetch_e_ = 1'b1;
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);

    // Fill while stalled, overflow write, then drain
    for (int k = 0; k < 5; k++) cycle(1'b0, 32'h100 + 32'(4 * k), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b1, 32'h0, 1'b0, 1'b1);

    // Streaming push/pop every cycle
    for (int k = 0; k < 16; k++) cycle(1'b0, 32'h200 + 32'(4 * k), 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);

    // Stall hold on head 'h300
    cycle(1'b0, 32'h300, 1'b1, 1'b1);
    cycle(1'b0, 32'h304, 1'b1, 1'b1);
    cycle(1'b0, 32'h308, 1'b1, 1'b1);
    cycle(1'b1, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h0, 1'b0, 1'b1);

    // Flush with three entries and a concurrent write
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h380 + 32'(4 * k), 1'b1, 1'b1);
    cycle(1'b0, 32'h400, 1'b0, 1'b0);
    cycle(1'b0, 32'h500, 1'b1, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);

    // Pointer wrap at occupancy 3
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h600 + 32'(4 * k), 1'b1, 1'b1);
    for (int k = 3; k < 13; k++) cycle(1'b0, 32'h600 + 32'(4 * k), 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    reset_ = 1'b0;
    #1;
    check_idle("async reset");
    sb.delete();
    @(posedge clk);
    #1;
    check_idle("reset mid");
    reset_ = 1'b1;
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h700, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
